// File: rtl/stage_memory_load_sized.sv
// stage_memory_load_sized
//   Memory-load pipeline stage. Holds an enabled load for READ_LATENCY cycles, pulses
//   is_complete, and captures the size/sign-extended lane of the aligned memory word.
//   Optional macro MEM_LOAD_MISALIGN_TRAP_EN: misaligned loads complete immediately
//   without a memory read, return 0 and raise load_fault.
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enable              load in flight (inputs held stable until is_complete)
//   i_effective_addr    byte address of the load
//   i_funct3            RV load funct3
//   mem_r_data          aligned memory word, valid when the wait counter reaches 0
//   mem_read_en         memory read request (comb)
//   mem_addr            word-aligned address (comb)
//   is_complete         load finishes this cycle (comb)
//   loaded_value        extended load result (registered)
//   load_fault          last completed load was misaligned (registered, macro only)
module stage_memory_load_sized #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [XLEN-1:0] i_effective_addr,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] mem_r_data,
  output logic            mem_read_en,
  output logic [XLEN-1:0] mem_addr,
  output logic            is_complete,
  output logic [XLEN-1:0] loaded_value,
  output logic            load_fault
);

  localparam int unsigned OFS = $clog2(XLEN / 8);
  localparam int unsigned CW  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("stage_memory_load_sized: XLEN must be 32 or 64");
    end
    if (READ_LATENCY > 15) begin : g_bad_latency
      $error("stage_memory_load_sized: READ_LATENCY must be 0..15");
    end
  endgenerate

  logic [CW-1:0]   cnt;
  logic [1:0]      size;
  logic            is_unsigned;
  logic [OFS-1:0]  off;
  logic [OFS-1:0]  lane_off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] extracted;

  // Decode access size; unsupported encodings fall back to a signed word load
  always_comb begin
    size        = i_funct3[1:0];
    is_unsigned = i_funct3[2];
    if (i_funct3 == 3'b111 || (XLEN == 32 && (i_funct3 == 3'b011 || i_funct3 == 3'b110))) begin
      size        = 2'd2;
      is_unsigned = 1'b0;
    end
  end

  // Lane byte offset: low address bits below the access size are dropped
  assign off = i_effective_addr[OFS-1:0];
  always_comb begin
    case (size)
      2'd0:    lane_off = off;
      2'd1:    lane_off = off & ~OFS'(1);
      2'd2:    lane_off = off & ~OFS'(3);
      default: lane_off = '0;
    endcase
  end

  assign shifted = mem_r_data >> {lane_off, 3'b000};

  // Sign/zero extension by OR-ing in an upper-bit mask
  always_comb begin
    case (size)
      2'd0: begin
        extracted = XLEN'(shifted[7:0]);
        if (!is_unsigned && shifted[7]) extracted = extracted | ~XLEN'(8'hFF);
      end
      2'd1: begin
        extracted = XLEN'(shifted[15:0]);
        if (!is_unsigned && shifted[15]) extracted = extracted | ~XLEN'(16'hFFFF);
      end
      2'd2: begin
        extracted = XLEN'(shifted[31:0]);
        if (!is_unsigned && shifted[31]) extracted = extracted | ~XLEN'(32'hFFFF_FFFF);
      end
      default: extracted = shifted;
    endcase
  end

  assign mem_addr = {i_effective_addr[XLEN-1:OFS], OFS'(0)};

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    case (size)
      2'd1:    misaligned = i_effective_addr[0];
      2'd2:    misaligned = (i_effective_addr[1:0] != 2'b00);
      2'd3:    misaligned = (i_effective_addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end

  assign is_complete = enable && ((cnt == '0) || misaligned);
  assign mem_read_en = enable && !misaligned;

  // Result and fault flag update only on completion
  always_ff @(posedge clock) begin
    if (reset) begin
      loaded_value <= '0;
      load_fault   <= 1'b0;
    end else if (is_complete) begin
      loaded_value <= misaligned ? '0 : extracted;
      load_fault   <= misaligned;
    end
  end
`else
  assign is_complete = enable && (cnt == '0);
  assign mem_read_en = enable;
  assign load_fault  = 1'b0;

  // Result updates only on completion
  always_ff @(posedge clock) begin
    if (reset) begin
      loaded_value <= '0;
    end else if (is_complete) begin
      loaded_value <= extracted;
    end
  end
`endif

  // Latency counter: reloads when idle or on completion, counts down while waiting
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= CW'(READ_LATENCY);
    end else if (!enable) begin
      cnt <= CW'(READ_LATENCY);
    end else if (is_complete) begin
      cnt <= CW'(READ_LATENCY);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_stage_memory_load_sized.sv
module tb_stage_memory_load_sized;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, rst3;
  logic        en1, en2, en3, en64;
  logic [31:0] addr32, data32;
  logic [2:0]  f3_32;
  logic [63:0] addr64, data64;
  logic [2:0]  f3_64;

  logic        rd1, rd2, rd3, rd64;
  logic [31:0] ma1, ma2, ma3;
  logic [63:0] ma64;
  logic        ic1, ic2, ic3, ic64;
  logic [31:0] lv1, lv2, lv3;
  logic [63:0] lv64;
  logic        lf1, lf2, lf3, lf64;

  int n_cmp = 0;
  int n_err = 0;

  stage_memory_load_sized #(.XLEN(32), .READ_LATENCY(1)) d1 (
    .clock(clock), .reset(rst), .enable(en1), .i_effective_addr(addr32), .i_funct3(f3_32),
    .mem_r_data(data32), .mem_read_en(rd1), .mem_addr(ma1), .is_complete(ic1),
    .loaded_value(lv1), .load_fault(lf1));

  stage_memory_load_sized #(.XLEN(32), .READ_LATENCY(2)) d2 (
    .clock(clock), .reset(rst), .enable(en2), .i_effective_addr(addr32), .i_funct3(f3_32),
    .mem_r_data(data32), .mem_read_en(rd2), .mem_addr(ma2), .is_complete(ic2),
    .loaded_value(lv2), .load_fault(lf2));

  stage_memory_load_sized #(.XLEN(32), .READ_LATENCY(3)) d3 (
    .clock(clock), .reset(rst3), .enable(en3), .i_effective_addr(addr32), .i_funct3(f3_32),
    .mem_r_data(data32), .mem_read_en(rd3), .mem_addr(ma3), .is_complete(ic3),
    .loaded_value(lv3), .load_fault(lf3));

  stage_memory_load_sized #(.XLEN(64), .READ_LATENCY(1)) d64 (
    .clock(clock), .reset(rst), .enable(en64), .i_effective_addr(addr64), .i_funct3(f3_64),
    .mem_r_data(data64), .mem_read_en(rd64), .mem_addr(ma64), .is_complete(ic64),
    .loaded_value(lv64), .load_fault(lf64));

  // Inputs of d1 must stay stable while a load is pending
  logic        held = 1'b0;
  logic [31:0] held_addr;
  logic [2:0]  held_f3;
  always @(posedge clock) begin
    if (held && en1)
      assert (addr32 == held_addr && f3_32 == held_f3)
        else $error("load inputs changed while enable high before completion");
    held      <= en1 && !ic1;
    held_addr <= addr32;
    held_f3   <= f3_32;
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec32_t;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
  } vec64_t;

  vec32_t v32[10];
  vec64_t v64[6];
  logic [31:0] prev1;
  logic [63:0] prev64;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One LAT=1 load on d1: idle in T, complete in T+1, result visible after that edge
  task automatic run_vec32(input string name, input vec32_t v);
    tick();
    addr32 = v.addr; f3_32 = v.f3; data32 = v.data; en1 = 1'b1;
    #1;
    chk({name, " ic@T"}, 64'(ic1), 64'd0);
    chk({name, " rd_en"}, 64'(rd1), 64'd1);
    chk({name, " mem_addr"}, 64'(ma1), 64'(v.addr & 32'hFFFF_FFFC));
    chk({name, " hold"}, 64'(lv1), 64'(prev1));
    tick();
    chk({name, " ic@T+1"}, 64'(ic1), 64'd1);
    tick();
    chk({name, " value"}, 64'(lv1), 64'(v.exp));
    chk({name, " fault"}, 64'(lf1), 64'd0);
    en1 = 1'b0;
    prev1 = v.exp;
  endtask

  task automatic run_vec64(input string name, input vec64_t v);
    tick();
    addr64 = v.addr; f3_64 = v.f3; data64 = v.data; en64 = 1'b1;
    #1;
    chk({name, " ic@T"}, 64'(ic64), 64'd0);
    chk({name, " mem_addr"}, ma64, v.addr & 64'hFFFF_FFFF_FFFF_FFF8);
    chk({name, " hold"}, lv64, prev64);
    tick();
    chk({name, " ic@T+1"}, 64'(ic64), 64'd1);
    tick();
    chk({name, " value"}, lv64, v.exp);
    en64 = 1'b0;
    prev64 = v.exp;
  endtask

  initial begin
    v32[0] = '{3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF};
    v32[1] = '{3'b000, 32'h103, 32'h80123456, 32'hFFFFFF80};
    v32[2] = '{3'b100, 32'h103, 32'h80123456, 32'h00000080};
    v32[3] = '{3'b001, 32'h102, 32'h80017FFF, 32'hFFFF8001};
    v32[4] = '{3'b101, 32'h100, 32'h80017FFF, 32'h00007FFF};
    v32[5] = '{3'b000, 32'h100, 32'h80123456, 32'h00000056};
    v32[6] = '{3'b001, 32'h100, 32'h00008000, 32'hFFFF8000};
    v32[7] = '{3'b100, 32'h101, 32'h80123456, 32'h00000034};
    v32[8] = '{3'b111, 32'h104, 32'h87654321, 32'h87654321};
    v32[9] = '{3'b011, 32'h108, 32'h80000000, 32'h80000000};

    v64[0] = '{3'b011, 64'h8, 64'h8000000000000001, 64'h8000000000000001};
    v64[1] = '{3'b110, 64'hC, 64'h8000000000000001, 64'h0000000080000000};
    v64[2] = '{3'b010, 64'hC, 64'h8000000000000001, 64'hFFFFFFFF80000000};
    v64[3] = '{3'b010, 64'h8, 64'h8000000000000001, 64'h0000000000000001};
    v64[4] = '{3'b000, 64'hF, 64'h8000000000000001, 64'hFFFFFFFFFFFFFF80};
    v64[5] = '{3'b101, 64'hE, 64'h8000000000000001, 64'h0000000000008000};

    rst = 1'b1; rst3 = 1'b1;
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; en64 = 1'b0;
    addr32 = '0; data32 = '0; f3_32 = 3'b010;
    addr64 = '0; data64 = '0; f3_64 = 3'b011;
    prev1 = '0; prev64 = '0;
    tick();
    tick();
    chk("reset lv", 64'(lv1), 64'd0);
    chk("reset lv64", lv64, 64'd0);
    chk("reset ic", 64'(ic1), 64'd0);
    chk("reset rd_en", 64'(rd1), 64'd0);
    chk("reset fault", 64'(lf1), 64'd0);
    rst = 1'b0; rst3 = 1'b0;

    for (int i = 0; i < 10; i++) run_vec32($sformatf("v32[%0d]", i), v32[i]);
    for (int i = 0; i < 6; i++) run_vec64($sformatf("v64[%0d]", i), v64[i]);

    // Misaligned LW 0x101 on the LAT=1 instance
    tick();
    addr32 = 32'h101; f3_32 = 3'b010; data32 = 32'hCAFEF00D; en1 = 1'b1;
    #1;
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    chk("mis ic@T", 64'(ic1), 64'd1);
    chk("mis rd_en", 64'(rd1), 64'd0);
    tick();
    chk("mis value", 64'(lv1), 64'd0);
    chk("mis fault", 64'(lf1), 64'd1);
    en1 = 1'b0;
    prev1 = 32'h0;
`else
    chk("mis ic@T", 64'(ic1), 64'd0);
    chk("mis rd_en", 64'(rd1), 64'd1);
    chk("mis mem_addr", 64'(ma1), 64'h100);
    tick();
    chk("mis ic@T+1", 64'(ic1), 64'd1);
    tick();
    chk("mis value", 64'(lv1), 64'hCAFEF00D);
    chk("mis fault", 64'(lf1), 64'd0);
    en1 = 1'b0;
    prev1 = 32'hCAFEF00D;
`endif
    // Following aligned load clears any fault
    run_vec32("after_mis", v32[3]);

    // Three back-to-back LW on LAT=2: pulses at T+2, T+5, T+8
    tick();
    addr32 = 32'h200; f3_32 = 3'b010; data32 = 32'h11223344; en2 = 1'b1;
    #1;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("b2b ic@T+%0d", c), 64'(ic2), 64'((c == 2) || (c == 5) || (c == 8)));
      tick();
    end
    en2 = 1'b0;
    chk("b2b value", 64'(lv2), 64'h11223344);

    // Enable dropped at T+1 on LAT=2: no pulse, value held, counter reloaded
    tick();
    addr32 = 32'h204; data32 = 32'h55667788; en2 = 1'b1;
    #1;
    chk("drop ic@T", 64'(ic2), 64'd0);
    tick();
    en2 = 1'b0;
    #1;
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("drop ic@T+%0d", c), 64'(ic2), 64'd0);
      tick();
    end
    chk("drop hold", 64'(lv2), 64'h11223344);
    en2 = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reload ic@T+%0d", c), 64'(ic2), 64'(c == 2));
      tick();
    end
    en2 = 1'b0;
    chk("reload value", 64'(lv2), 64'h55667788);

    // LAT=3: one normal load, then a load discarded by reset at T+1
    tick();
    addr32 = 32'h300; data32 = 32'h5A5A5A5A; en3 = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("lat3 ic@T+%0d", c), 64'(ic3), 64'(c == 3));
      tick();
    end
    en3 = 1'b0;
    chk("lat3 value", 64'(lv3), 64'h5A5A5A5A);
    tick();
    addr32 = 32'h304; data32 = 32'h0BADCAFE; en3 = 1'b1;
    #1;
    chk("rst ic@T", 64'(ic3), 64'd0);
    tick();
    rst3 = 1'b1;
    chk("rst ic@T+1", 64'(ic3), 64'd0);
    tick();
    rst3 = 1'b0; en3 = 1'b0;
    #1;
    chk("rst ic after", 64'(ic3), 64'd0);
    chk("rst value", 64'(lv3), 64'd0);
    // Fresh load after reset takes the full three cycles
    tick();
    en3 = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post-rst ic@T+%0d", c), 64'(ic3), 64'(c == 3));
      tick();
    end
    en3 = 1'b0;
    chk("post-rst value", 64'(lv3), 64'h0BADCAFE);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
